dmem_arbiter: RTL

Two-requester arbiter that shares the single-port `data_memory` between the `riscV` core's data port and a loader/debug port. The loader port preloads or inspects RAM at runtime. The block sits between the core, the loader and `data_memory`, and stalls the core when the loader owns the memory. The core keeps priority, with bounded loader starvation and optional locked loader bursts.

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arb_perf.sv | 25 ++
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and counter-width helper for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic {S_CPU, S_LDR} arb_state_e;

  typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_LDR} gnt_sel_e;

  localparam int PERF_W = 32;

  // Width able to hold 0..max_val-1, never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/dmem_arb_perf.sv
// rtl/dmem_arb_perf.sv - saturating conflict / cpu-stall event counters
module dmem_arb_perf
  import dmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              conflict,
  input  logic              stall,
  output logic [PERF_W-1:0] perf_conflict,
  output logic [PERF_W-1:0] perf_cpu_stall
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_conflict  <= '0;
      perf_cpu_stall <= '0;
    end else begin
      if (conflict && (perf_conflict != '1))
        perf_conflict <= perf_conflict + 1'b1;
      if (stall && (perf_cpu_stall != '1))
        perf_cpu_stall <= perf_cpu_stall + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/loader arbiter for data_memory; DMEM_ARB_PERF_EN adds perf counters
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_read,
  input  logic              ldr_write,
  input  logic              ldr_lock,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_gnt,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_conflict,
  output logic [PERF_W-1:0] perf_cpu_stall
`endif
);

  localparam int WAIT_W = cnt_w(MAX_WAIT);
  localparam int BEAT_W = cnt_w(MAX_BURST + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(MAX_BURST);

  arb_state_e        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_nxt;
  gnt_sel_e          gnt;
  logic              cpureq, ldrreq, burst_ok, from_burst;

  assign cpureq = cpu_read | cpu_write;
  assign ldrreq = ldr_read | ldr_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_CPU;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    beat_nxt   = beat_cnt;
    gnt        = GNT_NONE;
    from_burst = (state == S_LDR);
    burst_ok   = ldrreq && ldr_lock && (beat_cnt < BEAT_MAX);
    if (!reset_n) begin
      state_nxt = S_CPU;
      wait_nxt  = '0;
      beat_nxt  = '0;
    end else if (from_burst && burst_ok) begin
      gnt      = GNT_LDR;
      beat_nxt = beat_cnt + 1'b1;
    end else begin
      // Leaving a burst falls through to normal arbitration where the core wins conflicts.
      state_nxt = S_CPU;
      wait_nxt  = '0;
      beat_nxt  = '0;
      if (cpureq && ldrreq && (from_burst || (wait_cnt != WAIT_LAST))) begin
        gnt = GNT_CPU;
        if (!from_burst)
          wait_nxt = wait_cnt + 1'b1;
      end else if (ldrreq) begin
        gnt = GNT_LDR;
        if (ldr_lock) begin
          state_nxt = S_LDR;
          beat_nxt  = BEAT_W'(1);
        end
      end else if (cpureq) begin
        gnt = GNT_CPU;
      end
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (gnt)
      GNT_CPU: begin
        mem_write = cpu_write;
        mem_read  = cpu_read & ~cpu_write;
      end
      GNT_LDR: begin
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
        mem_write = ldr_write;
        mem_read  = ldr_read & ~ldr_write;
      end
      default: ;
    endcase
  end

  assign cpu_stall = reset_n & cpureq & (gnt != GNT_CPU);
  assign ldr_gnt   = ldrreq & (gnt == GNT_LDR);
  assign cpu_rdata = mem_rdata;
  assign ldr_rdata = mem_rdata;

`ifdef DMEM_ARB_PERF_EN
  dmem_arb_perf u_perf (
    .clk            (clk),
    .reset_n        (reset_n),
    .conflict       (cpureq & ldrreq),
    .stall          (cpu_stall),
    .perf_conflict  (perf_conflict),
    .perf_cpu_stall (perf_cpu_stall)
  );
`endif

endmodule
